// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state encoding, fixed opcodes and the TAP next-state rule.
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC,
        SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
        PA_DR  = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
        SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR = 4'hA, EX1_IR = 4'h9,
        PA_IR  = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } tap_state_e;

    localparam logic [4:0] IDCODE_OP = 5'h01;
    localparam logic [4:0] BYPASS_OP = 5'h1F;

    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        tap_state_e n;
        case (s)
            TLR:     n = tms ? TLR    : RTI;
            RTI:     n = tms ? SEL_DR : RTI;
            SEL_DR:  n = tms ? SEL_IR : CAP_DR;
            CAP_DR:  n = tms ? EX1_DR : SH_DR;
            SH_DR:   n = tms ? EX1_DR : SH_DR;
            EX1_DR:  n = tms ? UPD_DR : PA_DR;
            PA_DR:   n = tms ? EX2_DR : PA_DR;
            EX2_DR:  n = tms ? UPD_DR : SH_DR;
            UPD_DR:  n = tms ? SEL_DR : RTI;
            SEL_IR:  n = tms ? TLR    : CAP_IR;
            CAP_IR:  n = tms ? EX1_IR : SH_IR;
            SH_IR:   n = tms ? EX1_IR : SH_IR;
            EX1_IR:  n = tms ? UPD_IR : PA_IR;
            PA_IR:   n = tms ? EX2_IR : PA_IR;
            EX2_IR:  n = tms ? UPD_IR : SH_IR;
            UPD_IR:  n = tms ? SEL_DR : RTI;
            default: n = TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_tap_controller_if.sv
// jtag_tap_controller_if: JTAG pins plus the user data-register hookup.
interface jtag_tap_controller_if #(parameter int IR_WIDTH = 5);
    logic                jtag_tck, jtag_tms, jtag_tdi, jtag_tdo, jtag_tdo_en;
    logic [IR_WIDTH-1:0] instruction;
    logic                dr_load, dr_shift, dr_update, dr_serial_in, dr_serial_out;

    modport master (
        output jtag_tck, jtag_tms, jtag_tdi, dr_serial_out,
        input  jtag_tdo, jtag_tdo_en, instruction, dr_load, dr_shift, dr_update, dr_serial_in
    );

    modport slave (
        input  jtag_tck, jtag_tms, jtag_tdi, dr_serial_out,
        output jtag_tdo, jtag_tdo_en, instruction, dr_load, dr_shift, dr_update, dr_serial_in
    );
endinterface

// File: rtl/jtag_shift_register.sv
// jtag_shift_register: parallel-load shift register, new bit enters at LSB.
module jtag_shift_register #(parameter int WIDTH = 8) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) value <= '0;
        else if (load) value <= load_value;
        else if (shift) value <= {value[WIDTH-2:0], serial_in};
    end
endmodule

// File: rtl/jtag_tap_controller.sv
// jtag_tap_controller: IEEE 1149.1 TAP oversampled on clk, with IDCODE,
// BYPASS and an external user data register.
module jtag_tap_controller
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH     = 5,
    parameter logic [31:0] IDCODE_VALUE = 32'h00000001
) (
    input logic           clk,
    input logic           rst_n,
    jtag_tap_controller_if.slave jtag
);
    logic [1:0]          tck_s, tms_s, tdi_s;
    logic                tck_q, rise, fall, bypass;
    logic                sel_idcode, sel_bypass, sel_user;
    tap_state_e          state, state_d;
    logic [IR_WIDTH-1:0] ir_value;
    logic [31:0]         id_value;

    // rise and fall come from one synchronised bit, so they can never coincide
    assign rise       = tck_s[1] & ~tck_q;
    assign fall       = ~tck_s[1] & tck_q;
    assign state_d    = rise ? tap_next(state, tms_s[1]) : state;
    assign sel_idcode = jtag.instruction == IR_WIDTH'(IDCODE_OP);
    assign sel_bypass = jtag.instruction == IR_WIDTH'(BYPASS_OP);
    assign sel_user   = !sel_idcode && !sel_bypass;
    assign jtag.dr_serial_in = tdi_s[1];

    jtag_shift_register #(.WIDTH(IR_WIDTH)) u_ir (
        .clk(clk), .rst_n(rst_n),
        .load(rise && state == CAP_IR), .shift(rise && state == SH_IR),
        .serial_in(tdi_s[1]), .load_value(IR_WIDTH'(1)), .value(ir_value)
    );

    jtag_shift_register #(.WIDTH(32)) u_idcode (
        .clk(clk), .rst_n(rst_n),
        .load(rise && state == CAP_DR && sel_idcode), .shift(rise && state == SH_DR && sel_idcode),
        .serial_in(tdi_s[1]), .load_value(IDCODE_VALUE), .value(id_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_s            <= '0;
            tms_s            <= '0;
            tdi_s            <= '0;
            tck_q            <= 1'b0;
            state            <= TLR;
            bypass           <= 1'b0;
            jtag.instruction <= IR_WIDTH'(IDCODE_OP);
            jtag.jtag_tdo    <= 1'b0;
            jtag.jtag_tdo_en <= 1'b0;
            jtag.dr_load     <= 1'b0;
            jtag.dr_shift    <= 1'b0;
            jtag.dr_update   <= 1'b0;
        end else begin
            tck_s            <= {tck_s[0], jtag.jtag_tck};
            tms_s            <= {tms_s[0], jtag.jtag_tms};
            tdi_s            <= {tdi_s[0], jtag.jtag_tdi};
            tck_q            <= tck_s[1];
            state            <= state_d;
            jtag.jtag_tdo_en <= state_d == SH_DR || state_d == SH_IR;
            jtag.dr_load     <= rise && state == CAP_DR && sel_user;
            jtag.dr_shift    <= rise && state == SH_DR && sel_user;
            jtag.dr_update   <= fall && state == UPD_DR && sel_user;
            if (rise && sel_bypass && (state == CAP_DR || state == SH_DR))
                bypass <= state == SH_DR && tdi_s[1];
            if (state == TLR) jtag.instruction <= IR_WIDTH'(IDCODE_OP);
            else if (fall && state == UPD_IR) jtag.instruction <= ir_value;
            if (fall && state == SH_IR) jtag.jtag_tdo <= ir_value[IR_WIDTH-1];
            else if (fall && state == SH_DR)
                jtag.jtag_tdo <= sel_idcode ? id_value[31] : sel_bypass ? bypass : jtag.dr_serial_out;
        end
    end
endmodule

// File: doc/jtag_tap_controller.md
JTAG_TAP_CONTROLLER -- requirements
Module: jtag_tap_controller

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 5, instruction register width.
REQ-002 SHALL have parameter IDCODE_VALUE, default 32'h00000001, value captured by the IDCODE data register.
REQ-003 SHALL have port clk, input, 1, the single system clock; every flop is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port jtag_tck, input, 1, JTAG clock, asynchronous to clk.
REQ-006 SHALL have port jtag_tms, input, 1, test mode select.
REQ-007 SHALL have port jtag_tdi, input, 1, test data in.
REQ-008 SHALL have port jtag_tdo, output, 1, test data out.
REQ-009 SHALL have port jtag_tdo_en, output, 1, high while in SHIFT_DR or SHIFT_IR.
REQ-010 SHALL have port instruction, output, IR_WIDTH, current (updated) instruction.
REQ-011 SHALL have port dr_load, output, 1, one-clk pulse driving the user DR loadEnable.
REQ-012 SHALL have port dr_shift, output, 1, one-clk pulse driving the user DR shiftEnable.
REQ-013 SHALL have port dr_update, output, 1, one-clk update strobe for the user DR.
REQ-014 SHALL have port dr_serial_in, output, 1, registered TDI towards the user DR.
REQ-015 SHALL have port dr_serial_out, input, 1, serialOut from the user DR.

Function
REQ-016 SHALL synchronise jtag_tck, jtag_tms and jtag_tdi through two flops each, then detect TCK rise (sync 0->1) and TCK fall (sync 1->0) as one-clk events.
REQ-017 SHALL implement the 16-state IEEE 1149.1 TAP FSM (TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR, and the same six-plus-select for IR), advancing only on TCK rise using synchronised TMS.
REQ-018 SHALL reach TLR after 5 consecutive TCK rises with TMS=1 from any state.
REQ-019 SHALL, on a TCK rise in CAP_xR, load the selected register, and on a TCK rise in SH_xR, shift it (serial in = synchronised TDI), both in the same clk as the state transition.
REQ-020 SHALL shift MSB out first; the new bit enters at LSB.
REQ-021 SHALL capture IR_WIDTH'b...01 (LSB 1, bit1 0, remaining bits 0) into the IR shift stage.
REQ-022 SHALL copy the IR shift stage to instruction on the TCK fall while in UPD_IR; in TLR, instruction SHALL be forced to 5'h01 (IDCODE).
REQ-023 SHALL decode instruction 5'h01 as IDCODE (32-bit, captures IDCODE_VALUE), 5'h1F as BYPASS (1-bit, captures 0), and any other value as USER.
REQ-024 SHALL assert dr_load/dr_shift only when USER is selected; dr_update SHALL pulse on the TCK fall in UPD_DR with USER selected.
REQ-025 SHALL update jtag_tdo only on TCK fall, from the MSB of the active register (IR in SH_IR; IDCODE/BYPASS/dr_serial_out in SH_DR), and hold it otherwise.
REQ-026 SHALL ignore TCK rise and fall events in the same clk (glitch); the FSM holds.
REQ-027 SHALL produce no dr_* pulse in PA_xR or EX_xR states regardless of TCK activity.

Reset
REQ-028 SHALL, on rst_n low, asynchronously set FSM=TLR, instruction=5'h01, IR stage=0, IDCODE stage=0, bypass=0, jtag_tdo=0, jtag_tdo_en=0, dr_load/dr_shift/dr_update=0, sync flops=0.
REQ-029 SHALL abandon any shift in progress on reset mid-operation, with no update strobe generated.

Structure
REQ-030 SHALL place TAP state encoding (4-bit) and IDCODE/BYPASS opcodes in a shared package, jtag_pkg.
REQ-031 SHALL instantiate the team shift register sub-module jtag_shift_register for the IR stage (width IR_WIDTH) and the IDCODE stage (width 32).

Verification
REQ-032 SHALL verify reset: TMS=1 for 5 TCKs from RTI leaves the FSM in TLR with instruction=5'h01.
REQ-033 SHALL verify IDCODE: after reset, reaching SH_DR and running 32 TCKs returns 32'h00000001 MSB first on TDO.
REQ-034 SHALL verify IR scan: shifting 5'h1F gives captured 5'b00001 on TDO; after UPD_IR, instruction=5'h1F and a DR scan delays TDI by one TCK.
REQ-035 SHALL verify USER: with IR=5'h04, an 8-bit DR scan gives 1 dr_load, 8 dr_shift and 1 dr_update pulse.
REQ-036 SHALL verify pause: entering PA_DR after 3 shifts and holding 10 TCKs produces no dr_shift, and the scan resumes correctly via EX2_DR.
REQ-037 SHALL verify async reset: rst_n low mid SH_DR drops jtag_tdo_en within the same clk, with no dr_update pulse.
